// File: rtl/esc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : esc_pkg
//  Description : Shared defaults and the quadrature step lookup for the
//                encoder period meter.
//  Revision    : 1.0  initial release
// ============================================================================
package esc_pkg;

    localparam int          c_period_w_default    = 16;
    localparam int          c_avg_log2_default    = 2;
    localparam int          c_filt_len_default    = 4;
    localparam logic [15:0] c_stall_limit_default = 16'hFFFF;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_REV  = 2'd2,
        STEP_ERR  = 2'd3
    } quad_step_t;

    // Forward Gray sequence on {A,B}: 00 > 10 > 11 > 01 > 00
    function automatic logic [1:0] quad_next_fwd(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            2'b00:   nxt = 2'b10;
            2'b10:   nxt = 2'b11;
            2'b11:   nxt = 2'b01;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    function automatic quad_step_t quad_step(input logic [1:0] prev_ab,
                                             input logic [1:0] curr_ab);
        quad_step_t step;
        if (prev_ab == curr_ab)
            step = STEP_NONE;
        else if ((prev_ab ^ curr_ab) == 2'b11)
            step = STEP_ERR;
        else if (curr_ab == quad_next_fwd(prev_ab))
            step = STEP_FWD;
        else
            step = STEP_REV;
        return step;
    endfunction

endpackage
`default_nettype wire

// File: rtl/enc_glitch_filter.sv
`default_nettype none
// ============================================================================
//  Module      : enc_glitch_filter
//  Description : Two-flop synchroniser followed by a persistence filter; the
//                output follows the input only after FILT_LEN stable clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module enc_glitch_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic filt_out
);

    localparam int                 c_cnt_w    = $clog2(FILT_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILT_LEN - 1);

    logic [1:0]         r_sync;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_filt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], raw_in};
            // Count consecutive clocks where the synced level disagrees
            if (r_sync[1] != r_filt) begin
                if (r_cnt == c_cnt_last) begin
                    r_filt <= r_sync[1];
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign filt_out = r_filt;

endmodule
`default_nettype wire

// File: rtl/encoder_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_period_meter
//  Description : Quadrature decoder plus A-channel period meter with a
//                running average over 2**AVG_LOG2 samples and stall detect.
//  Revision    : 1.0  initial release
// ============================================================================
module encoder_period_meter
    import esc_pkg::*;
#(
    parameter int                  PERIOD_W    = c_period_w_default,
    parameter int                  AVG_LOG2    = c_avg_log2_default,
    parameter int                  FILT_LEN    = c_filt_len_default,
    parameter logic [PERIOD_W-1:0] STALL_LIMIT = PERIOD_W'(c_stall_limit_default)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                encoder_a,
    input  logic                encoder_b,
    output logic [PERIOD_W-1:0] period_out,
    output logic                period_valid,
    output logic                direction,
    output logic [15:0]         position,
    output logic                stalled,
    output logic                quad_error
);

    localparam int                 c_depth     = 1 << AVG_LOG2;
    localparam int                 c_sum_w     = PERIOD_W + AVG_LOG2;
    localparam logic [c_sum_w-1:0] c_sum_reset = c_sum_w'(STALL_LIMIT) << AVG_LOG2;

    // ---------------------------------------------------------------- input
    logic w_filt_a;
    logic w_filt_b;

    enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk      (clk),
        .rst      (rst),
        .raw_in   (encoder_a),
        .filt_out (w_filt_a)
    );

    enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk      (clk),
        .rst      (rst),
        .raw_in   (encoder_b),
        .filt_out (w_filt_b)
    );

    // --------------------------------------------------------------- decode
    logic [1:0]  r_prev_ab;
    logic [1:0]  w_curr_ab;
    quad_step_t  w_step;
    logic        w_a_rise;
    logic        r_direction;
    logic [15:0] r_position;
    logic        r_quad_error;

    assign w_curr_ab = {w_filt_a, w_filt_b};
    assign w_step    = quad_step(r_prev_ab, w_curr_ab);
    assign w_a_rise  = w_filt_a & ~r_prev_ab[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_ab    <= 2'b00;
            r_direction  <= 1'b0;
            r_position   <= 16'h0000;
            r_quad_error <= 1'b0;
        end else begin
            r_prev_ab    <= w_curr_ab;
            r_quad_error <= (w_step == STEP_ERR);
            case (w_step)
                STEP_FWD: begin
                    r_position  <= r_position + 16'd1;
                    r_direction <= 1'b1;
                end
                STEP_REV: begin
                    r_position  <= r_position - 16'd1;
                    r_direction <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // --------------------------------------------------------------- period
    logic [PERIOD_W-1:0] r_count;
    logic [PERIOD_W-1:0] w_count_inc;
    logic [PERIOD_W-1:0] r_buf [c_depth];
    logic [AVG_LOG2-1:0] r_wr_ptr;
    logic [PERIOD_W-1:0] w_oldest;
    logic [c_sum_w-1:0]  r_sum;
    logic [c_sum_w-1:0]  w_sum_next;
    logic [PERIOD_W-1:0] r_period_out;
    logic                r_period_valid;
    logic                r_stalled;

    // The saturated count doubles as the sample value (counter + 1, capped)
    assign w_count_inc = (r_count == STALL_LIMIT) ? STALL_LIMIT : r_count + 1'b1;
    assign w_oldest    = r_buf[r_wr_ptr];
    assign w_sum_next  = r_sum - c_sum_w'(w_oldest) + c_sum_w'(w_count_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count        <= '0;
            r_wr_ptr       <= '0;
            r_sum          <= c_sum_reset;
            r_period_out   <= '1;
            r_period_valid <= 1'b0;
            r_stalled      <= 1'b1;
            for (int i = 0; i < c_depth; i++) r_buf[i] <= STALL_LIMIT;
        end else if (!enable) begin
            r_count        <= '0;
            r_wr_ptr       <= '0;
            r_sum          <= c_sum_reset;
            r_period_out   <= '1;
            r_period_valid <= 1'b0;
            r_stalled      <= 1'b1;
            for (int i = 0; i < c_depth; i++) r_buf[i] <= STALL_LIMIT;
        end else begin
            r_period_valid <= 1'b0;
            if (w_a_rise) begin
                r_count <= '0;
                if (r_stalled) begin
                    // First edge after a stall only re-arms the counter
                    r_stalled <= 1'b0;
                end else begin
                    r_buf[r_wr_ptr] <= w_count_inc;
                    r_wr_ptr        <= r_wr_ptr + 1'b1;
                    r_sum           <= w_sum_next;
                    r_period_out    <= PERIOD_W'(w_sum_next >> AVG_LOG2);
                    r_period_valid  <= 1'b1;
                end
            end else begin
                r_count <= w_count_inc;
                if (w_count_inc == STALL_LIMIT) begin
                    r_stalled    <= 1'b1;
                    r_period_out <= '1;
                    r_sum        <= c_sum_reset;
                    r_wr_ptr     <= '0;
                    for (int i = 0; i < c_depth; i++) r_buf[i] <= STALL_LIMIT;
                end
            end
        end
    end

    assign period_out   = r_period_out;
    assign period_valid = r_period_valid;
    assign stalled      = r_stalled;
    assign direction    = r_direction;
    assign position     = r_position;
    assign quad_error   = r_quad_error;

endmodule
`default_nettype wire

// File: tb/tb_encoder_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder_period_meter
//  Description : Directed bench with a period scoreboard for the encoder
//                period meter (12-bit period, stall limit 0xFFF).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_encoder_period_meter;

    localparam int         c_period_w = 12;
    localparam int         c_lim      = 4095;
    localparam logic [11:0] c_limit   = 12'hFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        encoder_a;
    logic        encoder_b;
    logic [11:0] period_out;
    logic        period_valid;
    logic        direction;
    logic [15:0] position;
    logic        stalled;
    logic        quad_error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [11:0] exp_q [$];
    int          mbuf [4];
    int          mwp;
    bit          mstalled;
    int          last_rise;

    encoder_period_meter #(
        .PERIOD_W    (c_period_w),
        .AVG_LOG2    (2),
        .FILT_LEN    (4),
        .STALL_LIMIT (c_limit)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .encoder_a    (encoder_a),
        .encoder_b    (encoder_b),
        .period_out   (period_out),
        .period_valid (period_valid),
        .direction    (direction),
        .position     (position),
        .stalled      (stalled),
        .quad_error   (quad_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) mbuf[i] = c_lim;
        mwp      = 0;
        mstalled = 1'b1;
    endfunction

    // Reference: plain average of the last four recorded samples
    function automatic void note_a_rise();
        int gap;
        int sum;
        gap       = cyc - last_rise;
        last_rise = cyc;
        if (mstalled || gap > c_lim) begin
            for (int i = 0; i < 4; i++) mbuf[i] = c_lim;
            mwp      = 0;
            mstalled = 1'b0;
        end else begin
            mbuf[mwp] = gap;
            mwp       = (mwp + 1) % 4;
            sum       = 0;
            for (int i = 0; i < 4; i++) sum += mbuf[i];
            exp_q.push_back(12'(sum / 4));
        end
    endfunction

    task automatic set_ab(input logic a, input logic b);
        if (a && !encoder_a) note_a_rise();
        encoder_a = a;
        encoder_b = b;
    endtask

    task automatic rotate(input bit fwd, input int n, input int per);
        int q;
        q = per / 4;
        for (int i = 0; i < n; i++) begin
            if (fwd) begin
                set_ab(1'b1, 1'b0); tick(q);
                set_ab(1'b1, 1'b1); tick(q);
                set_ab(1'b0, 1'b1); tick(q);
                set_ab(1'b0, 1'b0); tick(per - 3 * q);
            end else begin
                set_ab(1'b0, 1'b1); tick(q);
                set_ab(1'b1, 1'b1); tick(q);
                set_ab(1'b1, 1'b0); tick(q);
                set_ab(1'b0, 1'b0); tick(per - 3 * q);
            end
        end
    endtask

    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid observed=0x%0h expected=no_strobe", period_out);
            end
            if (exp_q.size() != 0) begin
                automatic logic [11:0] e = exp_q.pop_front();
                checks++;
                assert (period_out === e) else begin
                    errors++;
                    $error("FAIL period_avg observed=0x%0h expected=0x%0h", period_out, e);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        encoder_a = 1'b0;
        encoder_b = 1'b0;
        last_rise = 0;
        model_reset();
        tick(3);
        rst = 1'b0;

        // Reset state and idle stall
        chk("rst_period_out", period_out, 32'hFFF);
        chk("rst_stalled", stalled, 1);
        chk("rst_valid", period_valid, 0);
        chk("rst_direction", direction, 0);
        chk("rst_position", position, 0);
        chk("rst_quad_error", quad_error, 0);
        tick(5000);
        chk("idle_stalled", stalled, 1);
        chk("idle_period_out", period_out, 32'hFFF);

        // Forward rotation, 1000-clk period
        rotate(1'b1, 1, 1000);
        chk("first_rise_unstall", stalled, 0);
        chk("first_rise_no_update", period_out, 32'hFFF);
        rotate(1'b1, 5, 1000);
        chk("fwd_period", period_out, 1000);
        chk("fwd_direction", direction, 1);
        chk("fwd_position", position, 24);

        // Reverse rotation and wrap
        rotate(1'b0, 6, 1000);
        chk("rev_position", position, 0);
        chk("rev_direction", direction, 0);
        set_ab(1'b0, 1'b1);
        tick(10);
        chk("pos_wrap_down", position, 16'hFFFF);
        set_ab(1'b0, 1'b0);
        tick(10);
        chk("pos_wrap_up", position, 0);
        chk("pos_wrap_up_dir", direction, 1);

        // Glitch rejection boundary
        encoder_a = 1'b1;
        tick(3);
        encoder_a = 1'b0;
        tick(20);
        chk("glitch_short_pos", position, 0);
        set_ab(1'b1, 1'b0);
        tick(4);
        set_ab(1'b0, 1'b0);
        tick(4);
        chk("glitch_long_pos", position, 1);
        chk("glitch_long_dir", direction, 1);
        tick(20);
        chk("glitch_back_pos", position, 0);
        chk("glitch_back_dir", direction, 0);

        // Simultaneous A/B change
        set_ab(1'b1, 1'b1);
        tick(7);
        chk("quad_err_pulse", quad_error, 1);
        chk("quad_err_pos", position, 0);
        tick(1);
        chk("quad_err_clear", quad_error, 0);
        tick(20);
        set_ab(1'b0, 1'b0);
        tick(30);
        chk("quad_err_pos2", position, 0);
        chk("quad_err_dir", direction, 0);

        // Edge exactly at the stall limit is recorded
        rotate(1'b1, 3, c_lim);
        chk("edge_wins_stalled", stalled, 0);
        rotate(1'b1, 6, 1000);
        chk("steady_period", period_out, 1000);
        chk("steady_stalled", stalled, 0);

        // Stop: stall exactly STALL_LIMIT clks after the last processed rise
        tick(3101);
        chk("stall_before_limit", stalled, 0);
        tick(1);
        chk("stall_at_limit", stalled, 1);
        chk("stall_period_out", period_out, 32'hFFF);

        // Enable pulse mid-rotation
        rotate(1'b1, 6, 1000);
        chk("pre_disable_pos", position, 60);
        enable = 1'b0;
        tick(1);
        chk("disable_period_out", period_out, 32'hFFF);
        chk("disable_stalled", stalled, 1);
        chk("disable_valid", period_valid, 0);
        chk("disable_pos", position, 60);
        enable = 1'b1;
        model_reset();
        rotate(1'b1, 2, 1000);
        chk("reenable_pos", position, 68);
        chk("reenable_period", period_out, 3321);

        // Asynchronous reset mid-operation
        set_ab(1'b1, 1'b0);
        tick(100);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pos", position, 0);
        chk("async_rst_stalled", stalled, 1);
        chk("async_rst_period", period_out, 32'hFFF);
        chk("async_rst_dir", direction, 0);
        encoder_a = 1'b0;
        encoder_b = 1'b0;
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(30);
        chk("post_rst_stalled", stalled, 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
